// File: rtl/ext_mem_lat.sv
// Simulation model of an external memory slave on the reg_native interface:
// programmable ack latency, byte enables, init-on-reset, error responses and drop injection.
module ext_mem_lat #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    MEM_ENTRIES = 1 << ADDR_WIDTH,
    parameter int                    ACK_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_vld,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    drop_inj,
    output logic                    ack_vld,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    err,
    output logic                    busy,
    output logic                    init_done,
    output logic [7:0]              drop_cnt
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int LAT_W = (ACK_LATENCY > 2) ? $clog2(ACK_LATENCY) : 1;
    // WAIT occupies cycles 1..ACK_LATENCY-1, so the counter starts at ACK_LATENCY-2.
    localparam logic [LAT_W-1:0]      LAT_LOAD   = LAT_W'((ACK_LATENCY >= 2) ? ACK_LATENCY - 2 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(MEM_ENTRIES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [LAT_W-1:0]        lat_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BE_W-1:0]         be_q;
    logic                    wr_q, rd_q, drop_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_ENTRIES];

    logic accept, in_range, bad_op, ack_cycle, do_write;

    assign accept    = (state == ST_IDLE) && req_vld && (wr_en || rd_en);
    assign in_range  = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(MEM_ENTRIES));
    assign bad_op    = !in_range || (wr_q && rd_q);
    assign ack_cycle = (state == ST_ACK) && !drop_q;
    assign do_write  = rst_n && ack_cycle && wr_q && !bad_op;

    assign busy      = (state != ST_IDLE);
    assign init_done = (state != ST_INIT);
    assign ack_vld   = ack_cycle;
    assign err       = ack_cycle && bad_op;
    assign rd_data   = (ack_cycle && rd_q && !bad_op) ? mem[addr_q] : '0;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_cnt == LAST_ENTRY) state_nxt = ST_IDLE;
            ST_IDLE: if (accept) state_nxt = (ACK_LATENCY == 1) ? ST_ACK : ST_WAIT;
            ST_WAIT: if (lat_cnt == '0) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            lat_cnt  <= '0;
            drop_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (accept) begin
                addr_q  <= addr;
                data_q  <= wr_data;
                be_q    <= wr_be;
                wr_q    <= wr_en;
                rd_q    <= rd_en;
                drop_q  <= drop_inj;
                lat_cnt <= LAT_LOAD;
            end else if (state == ST_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (req_vld && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // NOTE: the memory array has no reset branch; the INIT state sweeps it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_INIT) begin
            mem[init_cnt] <= INIT_VALUE;
        end else if (do_write) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) mem[addr_q][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_lat.sv
// Directed bench for ext_mem_lat: four instances (latency 2/1/5, 48-entry) driven from a vector
// table plus hand-written sequences for busy drops, back-to-back requests and mid-operation reset.
module tb_ext_mem_lat;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [4];
    logic        wr_en, rd_en, drop_inj;
    logic [5:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        ack_v [4];
    logic [31:0] rd_v  [4];
    logic        err_v [4];
    logic        busy_v[4];
    logic        done_v[4];
    logic [7:0]  dc_v  [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ext_mem_lat #(.ACK_LATENCY(2), .INIT_VALUE(IV)) u_main (
        .clk(clk), .rst_n(rst_n), .req_vld(req[0]), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .drop_inj(drop_inj), .ack_vld(ack_v[0]), .rd_data(rd_v[0]),
        .err(err_v[0]), .busy(busy_v[0]), .init_done(done_v[0]), .drop_cnt(dc_v[0]));

    ext_mem_lat #(.ACK_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_vld(req[1]), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .drop_inj(drop_inj), .ack_vld(ack_v[1]), .rd_data(rd_v[1]),
        .err(err_v[1]), .busy(busy_v[1]), .init_done(done_v[1]), .drop_cnt(dc_v[1]));

    ext_mem_lat #(.ACK_LATENCY(5), .INIT_VALUE(IV)) u_lat5 (
        .clk(clk), .rst_n(rst_n), .req_vld(req[2]), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .drop_inj(drop_inj), .ack_vld(ack_v[2]), .rd_data(rd_v[2]),
        .err(err_v[2]), .busy(busy_v[2]), .init_done(done_v[2]), .drop_cnt(dc_v[2]));

    ext_mem_lat #(.MEM_ENTRIES(48), .ACK_LATENCY(2), .INIT_VALUE(IV)) u_err (
        .clk(clk), .rst_n(rst_n), .req_vld(req[3]), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .drop_inj(drop_inj), .ack_vld(ack_v[3]), .rd_data(rd_v[3]),
        .err(err_v[3]), .busy(busy_v[3]), .init_done(done_v[3]), .drop_cnt(dc_v[3]));

    typedef struct {
        int          idx;
        logic        wr, rd;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        drop;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int idx, input logic w, input logic r, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic dr, input logic ea,
                       input logic ee, input logic [31:0] erd, input int el);
        vec_t v;
        v.idx = idx; v.wr = w; v.rd = r; v.addr = a; v.data = d; v.be = b; v.drop = dr;
        v.exp_ack = ea; v.exp_err = ee; v.exp_rd = erd; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    // One request on instance idx, then a fixed 12-cycle observation window.
    task automatic do_req(input int idx, input logic w, input logic r, input logic [5:0] a,
                          input logic [31:0] d, input logic [3:0] b, input logic dr,
                          output int n_ack, output int lat, output logic e,
                          output logic [31:0] rdv, output logic stray);
        @(negedge clk);
        wr_en = w; rd_en = r; addr = a; wr_data = d; wr_be = b; drop_inj = dr; req[idx] = 1'b1;
        n_ack = 0; lat = 0; e = 1'b0; rdv = '0; stray = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req[idx] = 1'b0; wr_en = 1'b0; rd_en = 1'b0; drop_inj = 1'b0;
            end
            if (ack_v[idx]) begin
                n_ack++;
                if (n_ack == 1) begin
                    lat = k; e = err_v[idx]; rdv = rd_v[idx];
                end
            end else if (err_v[idx] || rd_v[idx] != '0) begin
                stray = 1'b1;
            end
        end
    endtask

    task automatic wait_init(input string tag, input int exp0, input int exp3);
        int done_k[4];
        for (int i = 0; i < 4; i++) done_k[i] = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_k[i] < 0 && done_v[i]) done_k[i] = k;
        end
        check({tag, "_init_cycles_main"}, done_k[0], exp0);
        check({tag, "_init_cycles_48"}, done_k[3], exp3);
        check({tag, "_busy_after_init"}, busy_v[0], 1'b0);
    endtask

    initial begin
        int n_ack, lat;
        logic e, stray;
        logic [31:0] rdv;
        int done_k[4];

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; drop_inj = 1'b0;
        addr = '0; wr_data = '0; wr_be = '0;
        for (int i = 0; i < 4; i++) req[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ack", ack_v[0], 1'b0);
        check("rst_busy", busy_v[0], 1'b1);
        check("rst_init_done", done_v[0], 1'b0);
        check("rst_drop_cnt", dc_v[0], 8'd0);
        check("rst_err_rd", {err_v[0], rd_v[0][30:0]}, 32'd0);

        // Release reset; three req_vld cycles on the latency-1 instance land during INIT.
        rst_n = 1'b1;
        req[1] = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 4; i++) done_k[i] = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 3) begin
                req[1] = 1'b0; wr_en = 1'b0;
            end
            for (int i = 0; i < 4; i++) if (done_k[i] < 0 && done_v[i]) done_k[i] = k;
        end
        check("init_cycles_main", done_k[0], 64);
        check("init_cycles_lat5", done_k[2], 64);
        check("init_cycles_48", done_k[3], 48);
        check("init_drop_cnt_lat1", dc_v[1], 8'd3);
        check("init_drop_cnt_main", dc_v[0], 8'd0);

        //  idx wr rd addr  data           be       drop ack err exp_rd          lat
        add(0, 0, 1, 6'd0,  32'h0,         4'hF,    0,   1,  0,  IV,             2);
        add(0, 0, 1, 6'd63, 32'h0,         4'hF,    0,   1,  0,  IV,             2);
        add(0, 1, 0, 6'd3,  32'hFFFFFFFF,  4'hF,    0,   1,  0,  32'h0,          2);
        add(0, 1, 0, 6'd3,  32'h00000000,  4'b0101, 0,   1,  0,  32'h0,          2);
        add(0, 0, 1, 6'd3,  32'h0,         4'hF,    0,   1,  0,  32'hFF00FF00,   2);
        add(0, 1, 0, 6'd3,  32'h00000000,  4'b0000, 0,   1,  0,  32'h0,          2);
        add(0, 0, 1, 6'd3,  32'h0,         4'hF,    0,   1,  0,  32'hFF00FF00,   2);
        add(0, 1, 0, 6'd5,  32'h12345678,  4'hF,    0,   1,  0,  32'h0,          2);
        add(0, 0, 1, 6'd5,  32'h0,         4'hF,    0,   1,  0,  32'h12345678,   2);
        add(0, 1, 0, 6'd5,  32'hDEADBEEF,  4'hF,    1,   0,  0,  32'h0,          0);
        add(0, 0, 1, 6'd5,  32'h0,         4'hF,    0,   1,  0,  32'h12345678,   2);
        add(1, 1, 0, 6'd5,  32'h12345678,  4'hF,    0,   1,  0,  32'h0,          1);
        add(1, 0, 1, 6'd5,  32'h0,         4'hF,    0,   1,  0,  32'h12345678,   1);
        add(1, 0, 1, 6'd6,  32'h0,         4'hF,    0,   1,  0,  32'h0,          1);
        add(2, 1, 0, 6'd5,  32'h12345678,  4'hF,    0,   1,  0,  32'h0,          5);
        add(2, 0, 1, 6'd5,  32'h0,         4'hF,    0,   1,  0,  32'h12345678,   5);
        add(2, 0, 1, 6'd9,  32'h0,         4'hF,    1,   0,  0,  32'h0,          0);
        add(2, 0, 0, 6'd9,  32'h0,         4'hF,    0,   0,  0,  32'h0,          0);
        add(3, 1, 0, 6'd50, 32'h11111111,  4'hF,    0,   1,  1,  32'h0,          2);
        add(3, 0, 1, 6'd50, 32'h0,         4'hF,    0,   1,  1,  32'h0,          2);
        add(3, 1, 1, 6'd2,  32'h0,         4'hF,    0,   1,  1,  32'h0,          2);
        add(3, 0, 1, 6'd2,  32'h0,         4'hF,    0,   1,  0,  IV,             2);
        add(3, 0, 1, 6'd47, 32'h0,         4'hF,    0,   1,  0,  IV,             2);
        add(3, 1, 0, 6'd48, 32'h22222222,  4'hF,    0,   1,  1,  32'h0,          2);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            do_req(v.idx, v.wr, v.rd, v.addr, v.data, v.be, v.drop, n_ack, lat, e, rdv, stray);
            check($sformatf("v%0d_ack_count", i), n_ack, v.exp_ack ? 1 : 0);
            check($sformatf("v%0d_idle_outputs", i), stray, 1'b0);
            if (v.exp_ack) begin
                check($sformatf("v%0d_latency", i), lat, v.exp_lat);
                check($sformatf("v%0d_err", i), e, v.exp_err);
                check($sformatf("v%0d_rd_data", i), rdv, v.exp_rd);
            end
        end
        check("ignored_noop_drop_cnt", dc_v[2], 8'd0);
        check("lat1_drop_cnt_stable", dc_v[1], 8'd3);

        // Busy drops: accept a write, keep req_vld high through cycles 1 and 2 with other data.
        @(negedge clk);
        req[0] = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = 6'd10; wr_data = 32'h0A0A0A0A; wr_be = 4'hF;
        @(negedge clk);
        check("busy_cycle1", busy_v[0], 1'b1);
        addr = 6'd11; wr_data = 32'hBBBBBBBB;
        @(negedge clk);
        check("busy_ack_cycle2", ack_v[0], 1'b1);
        check("busy_ack_err", err_v[0], 1'b0);
        @(negedge clk);
        req[0] = 1'b0; wr_en = 1'b0;
        check("busy_cycle3_idle", busy_v[0], 1'b0);
        check("busy_cycle3_no_ack", ack_v[0], 1'b0);
        check("busy_drop_cnt", dc_v[0], 8'd2);
        do_req(0, 0, 1, 6'd10, 32'h0, 4'hF, 0, n_ack, lat, e, rdv, stray);
        check("busy_read10", rdv, 32'h0A0A0A0A);
        do_req(0, 0, 1, 6'd11, 32'h0, 4'hF, 0, n_ack, lat, e, rdv, stray);
        check("busy_read11_untouched", rdv, IV);

        // Back-to-back: a read issued the cycle after a write's ack is accepted and sees the write.
        @(negedge clk);
        req[0] = 1'b1; wr_en = 1'b1; addr = 6'd20; wr_data = 32'hC0FFEE00; wr_be = 4'hF;
        @(negedge clk);
        req[0] = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("b2b_write_ack", ack_v[0], 1'b1);
        @(negedge clk);
        req[0] = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("b2b_read_ack", ack_v[0], 1'b1);
        check("b2b_read_data", rd_v[0], 32'hC0FFEE00);
        check("b2b_drop_cnt", dc_v[0], 8'd2);

        // Reset one cycle before the expected ack of a write to addr 7.
        @(negedge clk);
        req[0] = 1'b1; wr_en = 1'b1; addr = 6'd7; wr_data = 32'h77777777; wr_be = 4'hF;
        @(negedge clk);
        req[0] = 1'b0; wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_no_ack", ack_v[0], 1'b0);
        check("midrst_busy", busy_v[0], 1'b1);
        check("midrst_init_done", done_v[0], 1'b0);
        check("midrst_drop_cnt", dc_v[0], 8'd0);
        rst_n = 1'b1;
        wait_init("reinit", 64, 48);
        do_req(0, 0, 1, 6'd7, 32'h0, 4'hF, 0, n_ack, lat, e, rdv, stray);
        check("midrst_read7_ack", n_ack, 1);
        check("midrst_read7_data", rdv, IV);

        // Saturation: continuous dropped requests on the latency-5 instance.
        @(negedge clk);
        req[2] = 1'b1; wr_en = 1'b1; drop_inj = 1'b1; addr = 6'd0;
        repeat (400) @(negedge clk);
        req[2] = 1'b0; wr_en = 1'b0; drop_inj = 1'b0;
        repeat (10) @(negedge clk);
        check("drop_cnt_saturates", dc_v[2], 8'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
